// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I load/store unit in front of a one-cycle-latency word-addressed data memory.
// Four-state sequencer (IDLE/ACCESS/WAIT/RESP) with byte-lane steering and load extension.
`default_nettype none

module dmem_lsu #(
  parameter int XLEN       = 32,
  parameter int DMEM_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  rsp_valid,
  output logic [XLEN-1:0]       rsp_rdata,
  output logic                  rsp_fault,
  output logic [DMEM_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [3:0]            mem_byteena,
  input  logic [XLEN-1:0]       mem_q
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]      state;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            fault_q;
  logic [XLEN-1:0] ld_q;

  logic            accept;
  logic            req_fault;
  logic [3:0]      req_be;
  logic [XLEN-1:0] req_wd;
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_ext;
  logic            unused_addr_hi;

  // Upper address bits fall outside the memory and simply wrap.
  assign unused_addr_hi = ^req_addr[XLEN-1:DMEM_WIDTH+2];

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);

  always_comb begin
    req_fault = 1'b0;
    if (req_we) begin
      req_fault = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      req_fault = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
      req_fault = 1'b1;
    end
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
      req_fault = 1'b1;
    end
  end

  always_comb begin
    req_be = 4'b1111;
    req_wd = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        req_be = 4'b0001 << req_addr[1:0];
        req_wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be = 4'b0011 << {req_addr[1], 1'b0};
        req_wd = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be = 4'b1111;
        req_wd = req_wdata;
      end
    endcase
    if (!req_we) begin
      req_be = 4'b1111;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      fault_q <= 1'b0;
      ld_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            off_q   <= req_addr[1:0];
            fault_q <= req_fault;
            state   <= req_fault ? RESP : ACCESS;
          end
        end
        ACCESS:  state <= we_q ? RESP : WAIT;
        WAIT: begin
          ld_q  <= mem_q;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side registers only move for legal requests; stores alone update write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr    <= '0;
      mem_byteena <= 4'b0000;
      mem_wdata   <= '0;
    end else if (accept && !req_fault) begin
      mem_addr    <= req_addr[DMEM_WIDTH+1:2];
      mem_byteena <= req_be;
      if (req_we) begin
        mem_wdata <= req_wd;
      end
    end
  end

  assign mem_rden = (state == ACCESS) && !we_q;
  assign mem_wren = (state == ACCESS) && we_q;

  assign ld_shift = ld_q >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
      3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign rsp_fault = (state == RESP) && fault_q;
  assign rsp_rdata = ((state == RESP) && !we_q && !fault_q) ? ld_ext : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed vector table plus hand-written back-to-back and reset-in-flight sequences.
`default_nettype none

module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rden;
  logic        mem_wren;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_q;
  logic [31:0] cur_memq;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.XLEN(32), .DMEM_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .mem_byteena(mem_byteena), .mem_q(mem_q)
  );

  // Memory model: read data valid only in the cycle after the rden cycle.
  always @(posedge clk) mem_q <= mem_rden ? cur_memq : 32'hBAD0_BAD0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memq;
    logic        fault;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [11:0] maddr;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_one(input vec_t v, input int idx);
    int strobes;
    bit got;
    strobes = 0;
    got = 0;
    @(negedge clk);
    cur_memq   = v.memq;
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    check($sformatf("v%0d_ready", idx), {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      if (mem_rden || mem_wren) begin
        strobes++;
        if (!v.fault) begin
          check($sformatf("v%0d_be", idx), {28'd0, mem_byteena}, {28'd0, v.be});
          check($sformatf("v%0d_maddr", idx), {20'd0, mem_addr}, {20'd0, v.maddr});
          check($sformatf("v%0d_wren", idx), {31'd0, mem_wren}, {31'd0, v.we});
          if (v.we) check($sformatf("v%0d_wdata", idx), mem_wdata, v.mwdata);
        end
      end
      if (rsp_valid) begin
        got = 1;
        check($sformatf("v%0d_lat", idx), c, v.lat);
        check($sformatf("v%0d_fault", idx), {31'd0, rsp_fault}, {31'd0, v.fault});
        check($sformatf("v%0d_rdata", idx), rsp_rdata, v.rdata);
      end
    end
    if (!got) check($sformatf("v%0d_timeout", idx), 32'd0, 32'd1);
    check($sformatf("v%0d_strobes", idx), strobes, v.fault ? 0 : 1);
  endtask

  vec_t vecs[13];
  vec_t lw0;

  initial begin
    //              we  f3      addr          wdata         memq          flt rdata         be       mwdata        maddr  lat
    vecs[0]  = '{1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        0, 32'h0,        4'b1111, 32'hDEADBEEF, 12'h4, 2};
    vecs[1]  = '{1'b1, 3'b000, 32'h13,       32'h000000A5, 32'h0,        0, 32'h0,        4'b1000, 32'hA5A5A5A5, 12'h4, 2};
    vecs[2]  = '{1'b0, 3'b000, 32'h13,       32'h0,        32'hA5000000, 0, 32'hFFFFFFA5, 4'b1111, 32'h0,        12'h4, 3};
    vecs[3]  = '{1'b0, 3'b100, 32'h13,       32'h0,        32'hA5000000, 0, 32'h000000A5, 4'b1111, 32'h0,        12'h4, 3};
    vecs[4]  = '{1'b0, 3'b001, 32'h02,       32'h0,        32'h80011234, 0, 32'hFFFF8001, 4'b1111, 32'h0,        12'h0, 3};
    vecs[5]  = '{1'b0, 3'b101, 32'h02,       32'h0,        32'h80011234, 0, 32'h00008001, 4'b1111, 32'h0,        12'h0, 3};
    vecs[6]  = '{1'b0, 3'b010, 32'h06,       32'h0,        32'h11111111, 1, 32'h0,        4'b1111, 32'h0,        12'h0, 1};
    vecs[7]  = '{1'b1, 3'b001, 32'h01,       32'h1234,     32'h0,        1, 32'h0,        4'b0011, 32'h0,        12'h0, 1};
    vecs[8]  = '{1'b0, 3'b011, 32'h00,       32'h0,        32'h22222222, 1, 32'h0,        4'b1111, 32'h0,        12'h0, 1};
    vecs[9]  = '{1'b1, 3'b001, 32'h02,       32'h0000BEEF, 32'h0,        0, 32'h0,        4'b1100, 32'hBEEFBEEF, 12'h0, 2};
    vecs[10] = '{1'b0, 3'b010, 32'h40000008, 32'h0,        32'h12345678, 0, 32'h12345678, 4'b1111, 32'h0,        12'h2, 3};
    vecs[11] = '{1'b1, 3'b100, 32'h00,       32'h55,       32'h0,        1, 32'h0,        4'b0001, 32'h0,        12'h0, 1};
    vecs[12] = '{1'b0, 3'b000, 32'h01,       32'h0,        32'h00007F00, 0, 32'h0000007F, 4'b1111, 32'h0,        12'h0, 3};
    lw0      = '{1'b0, 3'b010, 32'h00,       32'h0,        32'h12345678, 0, 32'h12345678, 4'b1111, 32'h0,        12'h0, 3};

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; cur_memq = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_outs", {31'd0, rsp_valid | rsp_fault | mem_rden | mem_wren}, 32'd0);
    check("rst_data", rsp_rdata | mem_wdata | {20'd0, mem_addr} | {28'd0, mem_byteena}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_one(vecs[i], i);

    // Back-to-back stores with req_valid held high.
    begin
      logic [6:0] rdy, stb, rv;
      logic prev;
      prev = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
      for (int k = 0; k < 7; k++) begin
        rdy[k] = req_ready;
        stb[k] = mem_rden | mem_wren;
        rv[k]  = rsp_valid;
        if (prev && stb[k]) check("b2b_consec_strobe", 32'd1, 32'd0);
        prev = stb[k];
        @(negedge clk);
      end
      req_valid = 1'b0;
      check("b2b_ready", {25'd0, rdy}, {25'd0, 7'b1001001});
      check("b2b_strobe", {25'd0, stb}, {25'd0, 7'b0010010});
      check("b2b_rsp", {25'd0, rv}, {25'd0, 7'b0100100});
      repeat (2) @(negedge clk);
    end

    // Reset asserted during the WAIT cycle of a load.
    begin
      int nrsp;
      nrsp = 0;
      @(negedge clk);
      cur_memq = 32'hFFFFFFFF;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
      req_addr = 32'h0; req_wdata = 32'h0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rw_access_rden", {31'd0, mem_rden}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rw_ready", {31'd0, req_ready}, 32'd1);
      check("rw_outs", {31'd0, rsp_valid | rsp_fault | mem_rden | mem_wren}, 32'd0);
      check("rw_data", rsp_rdata | mem_wdata | {20'd0, mem_addr} | {28'd0, mem_byteena}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (rsp_valid) nrsp++;
        @(negedge clk);
      end
      check("rw_no_rsp", nrsp, 0);
      run_one(lw0, 13);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter XLEN, default 32: data width; only 32 is supported.
REQ-002 Parameter DMEM_WIDTH, default 12: data-memory word-address width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port clk  in  1: clock; all state changes on the rising edge.
REQ-005 Port rst  in  1: reset, asynchronous, active-high.
REQ-006 Port req_valid  in  1: CPU load/store request.
REQ-007 Port req_ready  out  1: the block accepts a request this cycle.
REQ-008 Port req_we  in  1: 1 = store, 0 = load.
REQ-009 Port req_funct3  in  3: RV32I size code. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
REQ-010 Port req_addr  in  XLEN: byte address.
REQ-011 Port req_wdata  in  XLEN: store data, right-aligned.
REQ-012 Port rsp_valid  out  1: one-cycle response pulse.
REQ-013 Port rsp_rdata  out  XLEN: extended load data.
REQ-014 Port rsp_fault  out  1: misaligned access or illegal funct3, qualified by rsp_valid.
REQ-015 Port mem_addr  out  DMEM_WIDTH: word address, equal to req_addr[DMEM_WIDTH+1:2].
REQ-016 Port mem_wdata  out  XLEN: lane-replicated store data.
REQ-017 Port mem_rden / mem_wren  out  1 each: memory read / write strobes.
REQ-018 Port mem_byteena  out  4: byte-lane enables.
REQ-019 Port mem_q  in  XLEN: memory read data, valid in the cycle after the rden cycle.

Function
REQ-020 The state machine SHALL have four states: IDLE, ACCESS, WAIT and RESP.
REQ-021 In IDLE, req_ready = 1; in every other state, req_ready = 0.
REQ-022 On req_valid && req_ready, the block SHALL register we, funct3, addr and wdata.
- Legal request: next state is ACCESS.
- Faulting request: next state is RESP, with no memory strobe.
REQ-023 A request is a fault if any of the following holds:
- H/HU with addr[0] = 1;
- W with addr[1:0] != 0;
- load funct3 in {011, 110, 111};
- store funct3 not in {000, 001, 010}.
REQ-024 ACCESS lasts exactly one cycle and drives exactly one of mem_rden or mem_wren high.
- Store: next state is RESP.
- Load: next state is WAIT.
REQ-025 WAIT lasts one cycle; at its closing edge the block SHALL capture mem_q into the load-extraction register, then go to RESP.
REQ-026 RESP lasts one cycle with rsp_valid = 1, then returns to IDLE; there is no response backpressure.
REQ-027 Latency from the acceptance edge to the rsp_valid cycle:
- load: 3 cycles;
- store: 2 cycles;
- fault: 1 cycle.
REQ-028 Store byteena:
- SB = 4'b0001 << addr[1:0];
- SH = 4'b0011 << {addr[1], 1'b0};
- SW = 4'b1111.
REQ-029 Load byteena SHALL be 4'b1111.
REQ-030 Store mem_wdata:
- SB = {4{wdata[7:0]}};
- SH = {2{wdata[15:0]}};
- SW = wdata.
REQ-031 Load data SHALL be mem_q shifted right by addr[1:0]*8, then sign-extended (B, H) or zero-extended (BU, HU) from 8 or 16 bits; W SHALL pass through unchanged.
REQ-032 On a fault, rsp_rdata = 0 and rsp_fault = 1; otherwise rsp_fault = 0.
REQ-033 rsp_rdata = 0 for stores.
REQ-034 Address bits above DMEM_WIDTH+1 SHALL be ignored (address wraps within the memory).
REQ-035 mem_addr, mem_byteena and mem_wdata SHALL hold their registered values outside ACCESS.
REQ-036 mem_rden and mem_wren SHALL be 0 outside ACCESS.
REQ-037 req_valid outside IDLE SHALL be ignored, with no side effects.

Reset
REQ-038 rst = 1 SHALL immediately force:
- state = IDLE;
- req_ready = 1;
- rsp_valid = 0, rsp_fault = 0, rsp_rdata = 0;
- mem_rden = 0, mem_wren = 0;
- mem_addr = 0, mem_byteena = 0, mem_wdata = 0.
REQ-039 Reset during ACCESS, WAIT or RESP SHALL drop the in-flight access with no rsp_valid pulse; a strobe already sampled by memory is not undone.
REQ-040 The first request SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-041 The bench SHALL cover the following directed scenarios:
- SW addr 0x10, wdata 0xDEADBEEF -> one cycle of mem_wren = 1, mem_addr = 4, byteena = 1111, mem_wdata = 0xDEADBEEF; rsp_valid 2 cycles later, rsp_fault = 0.
- SB addr 0x13, wdata 0x000000A5 -> byteena = 1000, mem_wdata = 0xA5A5A5A5; then LB addr 0x13 with mem_q = 0xA5000000 -> rsp_rdata = 0xFFFFFFA5; LBU -> 0x000000A5; rsp 3 cycles after acceptance.
- LH addr 0x02 with mem_q = 0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001.
- LW addr 0x06 -> rsp_fault = 1, rsp_rdata = 0, no mem_rden/mem_wren, rsp_valid 1 cycle after acceptance; SH addr 0x01 -> fault; load funct3 = 011 -> fault.
- Back-to-back requests: req_valid held high -> req_ready = 0 from acceptance through RESP, next request accepted in the following IDLE cycle; mem strobe never high for 2 consecutive cycles.
- rst asserted during WAIT of an LW -> all outputs 0 and req_ready = 1 immediately, no rsp_valid; after release, an LW addr 0 with mem_q = 0x12345678 -> rsp_rdata = 0x12345678.
